store_req_queue: RTL and testbench

// - Decoupling FIFO of lsu_ctrl_t store/AMO requests between LSU issue demux and store unit.
// - Absorbs issue bursts while the store unit stalls on TLB miss or full store buffer.
// - Presents head as valid + ctrl; store unit consumes head with a one-cycle pop pulse.
// - Optional fall-through when empty, so an issued store reaches the store unit in the same cycle.

---
 rtl/store_req_queue_pkg.sv | 23 ++
 rtl/store_req_queue.sv | 109 ++++++++++
 tb/tb_store_req_queue.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/store_req_queue_pkg.sv
// Shared types for the store request queue. lsu_ctrl_t mirrors the LSU
// control word carried from the issue demux to the store unit.
package store_req_queue_pkg;

  // Store / AMO operator carried with each request.
  typedef enum logic [1:0] {
    OP_SW       = 2'd0,
    OP_SD       = 2'd1,
    OP_AMO_ADD  = 2'd2,
    OP_AMO_SWAP = 2'd3
  } fu_op_t;

  localparam int unsigned TRANS_ID_W = 3;

  typedef struct packed {
    logic [31:0]           vaddr;
    logic [31:0]           data;
    logic [3:0]            be;
    fu_op_t                operation;
    logic [TRANS_ID_W-1:0] trans_id;
  } lsu_ctrl_t;

endpackage

// File: rtl/store_req_queue.sv
// Decoupling FIFO of store/AMO requests between the LSU issue demux and the
// store unit. Optional fall-through lets a store issued into an empty queue
// reach the store unit in the same cycle.
//
// Handshakes: a push is accepted when push_valid_i & push_ready_o & ~flush_i.
// push_ready_o depends on registered state only, so a pop does not free a
// slot for a push in the same cycle. The store unit pulses pop_st_i for one
// cycle to consume the head and must only do so while st_valid_o is high.
module store_req_queue
  import store_req_queue_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter bit          FALL_THROUGH = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_valid_i,
  input  lsu_ctrl_t                  push_ctrl_i,
  output logic                       push_ready_o,
  output logic                       st_valid_o,
  output lsu_ctrl_t                  st_ctrl_o,
  input  logic                       pop_st_i,
  output logic [$clog2(DEPTH+1)-1:0] usage_o,
  output logic                       empty_o
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned USAGE_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [USAGE_W-1:0] usage_q, usage_d;
  lsu_ctrl_t          mem_q [DEPTH];

  logic full, empty;
  logic push_accepted, bypass, push_stored, pop_from_mem;

  // FIFO control, head/bypass mux and next-state for pointers and usage.
  always_comb begin
    full          = (usage_q == USAGE_W'(DEPTH));
    empty         = (usage_q == '0);
    push_accepted = push_valid_i & ~full & ~flush_i;
    // Bypass: empty queue, fall-through enabled, and the store unit takes
    // the incoming request straight away, so it never touches storage.
    bypass        = FALL_THROUGH & empty & push_accepted & pop_st_i;
    push_stored   = push_accepted & ~bypass;
    pop_from_mem  = pop_st_i & ~empty & ~flush_i;

    st_valid_o = 1'b0;
    st_ctrl_o  = '0;
    if (!empty) begin
      st_valid_o = ~flush_i;
      st_ctrl_o  = mem_q[rd_ptr_q];
    end else if (FALL_THROUGH && push_valid_i) begin
      st_valid_o = ~flush_i;
      st_ctrl_o  = push_ctrl_i;
    end

    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    usage_d  = usage_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      usage_d  = '0;
    end else begin
      if (push_stored)  wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_from_mem) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      usage_d = usage_q + USAGE_W'(push_stored) - USAGE_W'(pop_from_mem);
    end

    push_ready_o = ~full;
    usage_o      = usage_q;
    empty_o      = empty;
  end

  // Pointer and usage registers; flush zeroes them, reset does too.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      usage_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      usage_q  <= usage_d;
    end
  end

  // Entry storage; cleared on reset only to keep simulation X-free.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_stored) begin
      mem_q[wr_ptr_q] <= push_ctrl_i;
    end
  end

  a_no_push_when_full : assert property (
    @(posedge clk_i) disable iff (!rst_ni) push_stored |-> (usage_q != USAGE_W'(DEPTH)));

  a_no_pop_when_invalid : assert property (
    @(posedge clk_i) disable iff (!rst_ni) pop_st_i |-> st_valid_o);

  a_usage_bounded : assert property (
    @(posedge clk_i) disable iff (!rst_ni) usage_q <= USAGE_W'(DEPTH));

endmodule

// File: tb/tb_store_req_queue.sv
// Bench for store_req_queue: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based model.
module tb_store_req_queue;
  import store_req_queue_pkg::*;

  localparam int DEPTH   = 4;
  localparam int USAGE_W = $clog2(DEPTH + 1);
  localparam int CTRL_W  = $bits(lsu_ctrl_t);

  logic               clk_i = 1'b0;
  logic               rst_ni;
  logic               flush_i;
  logic               push_valid_i;
  lsu_ctrl_t          push_ctrl_i;
  logic               push_ready_o;
  logic               st_valid_o;
  lsu_ctrl_t          st_ctrl_o;
  logic               pop_st_i;
  logic [USAGE_W-1:0] usage_o;
  logic               empty_o;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Model: ordered contents of the queue, head at index 0.
  logic [CTRL_W-1:0] exp_q [$];

  store_req_queue #(.DEPTH(DEPTH), .FALL_THROUGH(1'b1)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .flush_i      (flush_i),
    .push_valid_i (push_valid_i),
    .push_ctrl_i  (push_ctrl_i),
    .push_ready_o (push_ready_o),
    .st_valid_o   (st_valid_o),
    .st_ctrl_o    (st_ctrl_o),
    .pop_st_i     (pop_st_i),
    .usage_o      (usage_o),
    .empty_o      (empty_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic lsu_ctrl_t mk(input int tag);
    lsu_ctrl_t c;
    c.vaddr     = 32'h100 * tag;
    c.data      = $urandom;
    c.be        = 4'($urandom_range(0, 15));
    c.operation = fu_op_t'($urandom_range(0, 3));
    c.trans_id  = 3'(tag);
    return c;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic pv, input lsu_ctrl_t c, input logic p, input logic f);
    push_valid_i = pv;
    push_ctrl_i  = c;
    pop_st_i     = p;
    flush_i      = f;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // ---------------- model update ----------------
  always @(posedge clk_i or negedge rst_ni) begin
    bit acc;
    bit head_valid;
    if (!rst_ni) begin
      exp_q.delete();
    end else if (flush_i) begin
      exp_q.delete();
    end else begin
      acc        = push_valid_i && (exp_q.size() != DEPTH);
      head_valid = (exp_q.size() != 0) || push_valid_i;
      if (pop_st_i && head_valid) begin
        if (exp_q.size() == 0) acc = 1'b0;  // consumed on the fly
        else void'(exp_q.pop_front());
      end
      if (acc) exp_q.push_back(push_ctrl_i);
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk_i) begin
    bit exp_valid;
    if (rst_ni && cmp_en) begin
      exp_valid = !flush_i && ((exp_q.size() != 0) || push_valid_i);
      check("push_ready", push_ready_o, exp_q.size() != DEPTH);
      check("st_valid", st_valid_o, exp_valid);
      check("usage", usage_o, exp_q.size());
      check("empty", empty_o, exp_q.size() == 0);
      if (exp_valid)
        check("st_ctrl", st_ctrl_o, (exp_q.size() != 0) ? exp_q[0] : push_ctrl_i);
      if (pop_st_i) check("pop_while_invalid", st_valid_o, 1'b1);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    lsu_ctrl_t c;
    bit pv, p, f;
    int pop_bias;

    rst_ni = 1'b0;
    idle();
    #8;
    check("rst_push_ready", push_ready_o, 1'b1);
    check("rst_st_valid", st_valid_o, 1'b0);
    check("rst_st_ctrl", st_ctrl_o, '0);
    check("rst_usage", usage_o, 0);
    check("rst_empty", empty_o, 1'b1);
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    cmp_en = 1'b1;
    step();

    // Fall-through with same-cycle pop
    c = mk(3);
    drive(1'b1, c, 1'b1, 1'b0);
    #2;
    check("ft_valid", st_valid_o, 1'b1);
    check("ft_trans_id", st_ctrl_o.trans_id, 3);
    check("ft_usage", usage_o, 0);
    step();
    idle();
    #2;
    check("ft_usage_after", usage_o, 0);
    check("ft_empty_after", empty_o, 1'b1);
    step();

    // Fill to full, fifth push refused, drain in order
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, mk(i), 1'b0, 1'b0);
      step();
    end
    idle();
    #2;
    check("fill_usage", usage_o, 4);
    check("fill_ready", push_ready_o, 1'b0);
    drive(1'b1, mk(5), 1'b0, 1'b0);
    step();
    idle();
    #2;
    check("fill_5th_ignored", usage_o, 4);
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      #2;
      check("fill_order", st_ctrl_o.trans_id, i);
      step();
    end
    idle();
    #2;
    check("fill_drained", empty_o, 1'b1);
    step();

    // Full + pop + push in the same cycle
    for (int i = 11; i <= 14; i++) begin
      drive(1'b1, mk(i), 1'b0, 1'b0);
      step();
    end
    drive(1'b1, mk(15), 1'b1, 1'b0);
    #2;
    check("fullpop_ready", push_ready_o, 1'b0);
    step();
    idle();
    #2;
    check("fullpop_usage", usage_o, 3);
    check("fullpop_ready_next", push_ready_o, 1'b1);
    for (int i = 12; i <= 14; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      #2;
      check("fullpop_order", st_ctrl_o.vaddr, 32'h100 * i);
      step();
    end
    idle();
    step();

    // Wrap: pushes with pops one cycle behind
    for (int i = 0; i <= 10; i++) begin
      if (i < 10) drive(1'b1, mk(20 + i), (i > 0), 1'b0);
      else        drive(1'b0, '0, 1'b1, 1'b0);
      #2;
      if (i > 0) check("wrap_order", st_ctrl_o.vaddr, 32'h100 * (20 + i - 1));
      check("wrap_usage_le2", (usage_o <= 2), 1'b1);
      step();
    end
    idle();
    step();

    // Flush with a concurrent push
    for (int i = 40; i <= 42; i++) begin
      drive(1'b1, mk(i), 1'b0, 1'b0);
      step();
    end
    idle();
    #2;
    check("flush_pre_usage", usage_o, 3);
    drive(1'b1, mk(43), 1'b0, 1'b1);
    #2;
    check("flush_valid", st_valid_o, 1'b0);
    step();
    idle();
    #2;
    check("flush_usage", usage_o, 0);
    check("flush_empty", empty_o, 1'b1);
    check("flush_st_valid", st_valid_o, 1'b0);
    drive(1'b1, mk(44), 1'b0, 1'b0);
    step();
    idle();
    #2;
    check("flush_dropped_push", st_ctrl_o.vaddr, 32'h100 * 44);
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    idle();
    step();

    // Asynchronous reset mid-burst
    drive(1'b1, mk(50), 1'b0, 1'b0);
    step();
    drive(1'b1, mk(51), 1'b0, 1'b0);
    step();
    idle();
    #2;
    check("arst_pre_usage", usage_o, 2);
    rst_ni = 1'b0;
    #1;
    check("arst_push_ready", push_ready_o, 1'b1);
    check("arst_st_valid", st_valid_o, 1'b0);
    check("arst_st_ctrl", st_ctrl_o, '0);
    check("arst_usage", usage_o, 0);
    check("arst_empty", empty_o, 1'b1);
    step();
    rst_ni = 1'b1;
    drive(1'b1, mk(60), 1'b0, 1'b0);
    step();
    drive(1'b1, mk(61), 1'b0, 1'b0);
    step();
    idle();
    #2;
    check("arst_first_out", st_ctrl_o.vaddr, 32'h100 * 60);
    check("arst_post_usage", usage_o, 2);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      step();
    end

    // Randomized traffic; pop pressure alternates to reach both full and empty
    for (int k = 0; k < 400; k++) begin
      pop_bias = ((k / 50) % 2 == 0) ? 1 : 3;
      pv = ($urandom_range(0, 3) != 0);
      f  = ($urandom_range(0, 24) == 0);
      p  = !f && ((exp_q.size() != 0) || pv) && ($urandom_range(0, 3) < pop_bias);
      drive(pv, mk(100 + k), p, f);
      step();
    end

    idle();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
